sht40_sequencer: RTL
====================

// Module: sht40_sequencer
// PURPOSE
//  Command sequencer for the SHT40 sensor on i2c_master: on start (or periodically), issues the
//  high-precision measure command 0xFD, waits out conversion, reads 6 bytes, CRC-checks both words.
//  Publishes raw temperature/RH words. Drives the i2c_master command-side inputs. Sole master client.
// PARAMETERS
//  CMD_MEASURE      8'hFD     command byte sent in the write phase
//  MEAS_WAIT_CYCLES 20'd9000  clk cycles between write-phase end and read-phase start (>= 9 ms conversion)
//  TIMEOUT_CYCLES   20'd65535 max cycles in any master-wait state before abort
//  AUTO_PERIOD      24'd0     0 = start-triggered only; else restart period in clk cycles from IDLE entry
// PORTS
//  clk              in   1   system clock
//  rst              in   1   async active-high reset
//  start            in   1   one-cycle request; honoured only in IDLE
//  busy             out  1   high in every state except IDLE
//  temp_raw         out  16  last CRC-good temperature word (MSB first on bus)
//  rh_raw           out  16  last CRC-good humidity word
//  data_valid       out  1   one-cycle pulse when temp_raw/rh_raw update
//  crc_fail         out  1   one-cycle pulse on CRC mismatch of either word
//  timeout_err      out  1   one-cycle pulse on timeout abort
//  Processor_Ready  out  1   to master: begin a transaction (level, held until transaction accepted)
//  Command_Data_Frames out 8 to master: byte to write
//  i2c_writes       out  1   to master: 0 = single command frame
//  SHT_Reads        out  4   to master: read-byte terminal count (4'd5 = 6 bytes)
//  CRC_Error        out  1   to master: abort read; one-cycle pulse
//  Frames_Read      in   1   from master: write frame acknowledged
//  Data_Received    in   8   from master: received byte
//  Byte_Strobe      in   1   from master: one-cycle, Data_Received valid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; Command_Data_Frames=CMD_MEASURE, SHT_Reads=4'd5; counters 0.
//  Abort on rst mid-transaction: outputs drop immediately, temp_raw/rh_raw cleared, no pulses.
//  States:
//   IDLE   : start (or auto-period counter hits AUTO_PERIOD-1) -> CMD; otherwise hold.
//   CMD    : Processor_Ready=1; Frames_Read -> WAIT (Processor_Ready=0 same edge).
//   WAIT   : count 0..MEAS_WAIT_CYCLES-1, then -> READ. No timeout here.
//   READ   : Processor_Ready=1 until first Byte_Strobe; each strobe stores byte k (k=0..5) into rx[k];
//            CRC-8 (poly 0x31, init 0xFF, no reflect, no xorout) over rx[0..1] vs rx[2], rx[3..4] vs rx[5].
//            Word-1 CRC evaluated the cycle after byte 2 strobe; mismatch -> CRC_Error+crc_fail pulse, -> IDLE.
//            After byte 5 strobe -> CHECK.
//   CHECK  : one cycle; word-2 CRC ok -> temp_raw={rx0,rx1}, rh_raw={rx3,rx4}, data_valid pulse;
//            mismatch -> crc_fail pulse (no CRC_Error: master already ending); -> IDLE.
//  Timeout: counter resets on state entry and on every Frames_Read/Byte_Strobe; in CMD/READ reaching
//   TIMEOUT_CYCLES-1 -> timeout_err pulse, Processor_Ready=0, -> IDLE.
//  start while busy ignored (not queued). start and auto-period on same cycle: one transaction.
//  Byte_Strobe outside READ ignored; 7th+ strobe in READ impossible (state left), ignored.
//  Outputs registered; data_valid 1 cycle after last strobe + CHECK = 2 cycles after byte-5 strobe.
//  Auto-period counter runs only in IDLE, clears on leaving IDLE; AUTO_PERIOD=0 disables it.
// TESTING
//  1 start; Frames_Read after 5 cycles; bytes 66 66 93 80 00 A2 -> CRC good, temp_raw=16'h6666,
//    rh_raw=16'h8000, data_valid 1 pulse, Processor_Ready low in WAIT for exactly MEAS_WAIT_CYCLES.
//  2 bytes BE EF 92 BE EF 00 -> word-1 ok, word-2 bad: crc_fail pulse, no CRC_Error, outputs unchanged.
//  3 bytes BE EF 00 .. -> CRC_Error+crc_fail pulse one cycle after 3rd strobe, state IDLE, busy=0.
//  4 start, no Frames_Read -> timeout_err at TIMEOUT_CYCLES, Processor_Ready=0; repeat in READ after 2 bytes.
//  5 rst asserted mid-READ (byte 3) -> all outputs 0 same cycle; fresh start completes normally.
//  6 AUTO_PERIOD=100, start held 0 -> transactions relaunch 100 cycles after each IDLE entry; start while busy ignored.

Source files
------------

// File: rtl/sht40_sequencer.sv
// sht40_sequencer: drives i2c_master through an SHT40 measure/read cycle, CRC-checks both words and publishes the raw results
module sht40_sequencer #(
  parameter logic [7:0]  CMD_MEASURE      = 8'hFD,
  parameter logic [19:0] MEAS_WAIT_CYCLES = 20'd9000,
  parameter logic [19:0] TIMEOUT_CYCLES   = 20'd65535,
  parameter logic [23:0] AUTO_PERIOD      = 24'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [15:0] temp_raw,
  output logic [15:0] rh_raw,
  output logic        data_valid,
  output logic        crc_fail,
  output logic        timeout_err,
  output logic        Processor_Ready,
  output logic [7:0]  Command_Data_Frames,
  output logic        i2c_writes,
  output logic [3:0]  SHT_Reads,
  output logic        CRC_Error,
  input  logic        Frames_Read,
  input  logic [7:0]  Data_Received,
  input  logic        Byte_Strobe
);
  typedef enum logic [2:0] {IDLE, CMD, WAIT, READ, CHECK} state_t;
  state_t      state;
  logic [19:0] cnt;
  logic [23:0] acnt;
  logic [7:0]  rx [0:5];
  logic [2:0]  k;
  logic        chk1;
  logic        word1_ok, word2_ok, auto_hit, to_hit;
  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] d;
    logic [7:0]  c;
    d = {a, b};
    c = 8'hFF;
    for (int i = 15; i >= 0; i--)
      c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
    return c;
  endfunction
  assign word1_ok = crc8(rx[0], rx[1]) == rx[2];
  assign word2_ok = crc8(rx[3], rx[4]) == rx[5];
  assign auto_hit = (AUTO_PERIOD != 24'd0) && (acnt == AUTO_PERIOD - 24'd1);
  assign to_hit   = cnt == TIMEOUT_CYCLES - 20'd1;
  assign Command_Data_Frames = CMD_MEASURE;
  assign i2c_writes = 1'b0;
  assign SHT_Reads  = 4'd5;
  // transaction sequencer; cnt is the wait counter in WAIT and the timeout counter in CMD/READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      temp_raw        <= '0;
      rh_raw          <= '0;
      data_valid      <= 1'b0;
      crc_fail        <= 1'b0;
      timeout_err     <= 1'b0;
      Processor_Ready <= 1'b0;
      CRC_Error       <= 1'b0;
      cnt             <= '0;
      acnt            <= '0;
      rx              <= '{default: '0};
      k               <= '0;
      chk1            <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      crc_fail    <= 1'b0;
      timeout_err <= 1'b0;
      CRC_Error   <= 1'b0;
      case (state)
        IDLE: begin
          acnt <= acnt + 24'd1;
          if (start || auto_hit) begin
            state           <= CMD;
            busy            <= 1'b1;
            Processor_Ready <= 1'b1;
            cnt             <= '0;
            acnt            <= '0;
          end
        end
        CMD: begin
          if (Frames_Read) begin
            state           <= WAIT;
            Processor_Ready <= 1'b0;
            cnt             <= '0;
          end else if (to_hit) begin
            state           <= IDLE;
            busy            <= 1'b0;
            Processor_Ready <= 1'b0;
            timeout_err     <= 1'b1;
          end else cnt <= cnt + 20'd1;
        end
        WAIT: begin
          if (cnt == MEAS_WAIT_CYCLES - 20'd1) begin
            state           <= READ;
            Processor_Ready <= 1'b1;
            cnt             <= '0;
            k               <= '0;
            chk1            <= 1'b0;
          end else cnt <= cnt + 20'd1;
        end
        READ: begin
          chk1 <= 1'b0;
          if (chk1 && !word1_ok) begin
            state           <= IDLE;
            busy            <= 1'b0;
            Processor_Ready <= 1'b0;
            CRC_Error       <= 1'b1;
            crc_fail        <= 1'b1;
          end else if (Byte_Strobe) begin
            rx[k]           <= Data_Received;
            k               <= k + 3'd1;
            cnt             <= '0;
            Processor_Ready <= 1'b0;
            chk1            <= k == 3'd2;
            if (k == 3'd5) state <= CHECK;
          end else if (to_hit) begin
            state           <= IDLE;
            busy            <= 1'b0;
            Processor_Ready <= 1'b0;
            timeout_err     <= 1'b1;
          end else cnt <= cnt + 20'd1;
        end
        CHECK: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (word2_ok) begin
            temp_raw   <= {rx[0], rx[1]};
            rh_raw     <= {rx[3], rx[4]};
            data_valid <= 1'b1;
          end else crc_fail <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
